// File: rtl/bounce_gen_if.sv
// Command/status bundle between a bounce_gen emulator and whatever drives it.
// The master supplies the clean command level; the slave returns the bouncing contact.
interface bounce_gen_if;
  logic       cmd;
  logic       bounce_en;
  logic       btn_out;
  logic       busy;
  logic [7:0] glitch_cnt;

  modport master (output cmd, bounce_en, input btn_out, busy, glitch_cnt);
  modport slave  (input cmd, bounce_en, output btn_out, busy, glitch_cnt);
endinterface

// File: rtl/bounce_gen.sv
// Mechanical-switch emulator: turns a clean command level into a deterministic
// contact-bounce waveform, sampled from an LFSR at a fixed tick rate.
//
// state  | meaning
// IDLE   | btn_out settled at level; bypass edges or start of a bounce window
// BOUNCE | window active; btn_out sampled from the LFSR on each tick until settle
module bounce_gen #(
  parameter int          TICK_M       = 1_000_000,
  parameter int          BOUNCE_TICKS = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  bounce_gen_if.slave bus
);

  localparam int          TW       = (TICK_M > 1) ? $clog2(TICK_M) : 1;
  localparam int          CW       = $clog2(BOUNCE_TICKS + 1);
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] TAPS     = 16'hB400;

  typedef enum logic {IDLE, BOUNCE} state_t;

  state_t          state;
  logic            level;
  logic            target;
  logic [CW-1:0]   cnt;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [15:0]     lfsr;
  logic [15:0]     lfsr_nxt;

  // Free-running; deliberately never re-phased by cmd activity.
  assign tick = (tick_cnt == TW'(TICK_M - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  assign lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     lfsr <= SEED_EFF;
    else if (tick) lfsr <= lfsr_nxt;
  end

  function automatic logic [7:0] sat_inc(input logic [7:0] g, input logic chg);
    return (chg && (g != 8'hFF)) ? g + 8'd1 : g;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      level          <= 1'b0;
      target         <= 1'b0;
      cnt            <= '0;
      bus.btn_out    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.glitch_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd != level) begin
            if (bus.bounce_en) begin
              // First contact is itself an edge, so the fresh count starts at one.
              target         <= bus.cmd;
              cnt            <= '0;
              bus.btn_out    <= bus.cmd;
              bus.glitch_cnt <= sat_inc(8'd0, bus.cmd != bus.btn_out);
              bus.busy       <= 1'b1;
              state          <= BOUNCE;
            end else begin
              level          <= bus.cmd;
              bus.btn_out    <= bus.cmd;
              bus.glitch_cnt <= sat_inc(bus.glitch_cnt, bus.cmd != bus.btn_out);
            end
          end
        end
        BOUNCE: begin
          if (bus.cmd != target) begin
            target         <= bus.cmd;
            cnt            <= '0;
            bus.btn_out    <= bus.cmd;
            bus.glitch_cnt <= sat_inc(bus.glitch_cnt, bus.cmd != bus.btn_out);
          end else if (tick && (cnt == CW'(BOUNCE_TICKS - 1))) begin
            level          <= target;
            bus.btn_out    <= target;
            bus.glitch_cnt <= sat_inc(bus.glitch_cnt, target != bus.btn_out);
            bus.busy       <= 1'b0;
            state          <= IDLE;
          end else if (tick) begin
            bus.btn_out    <= lfsr[0];
            bus.glitch_cnt <= sat_inc(bus.glitch_cnt, lfsr[0] != bus.btn_out);
            cnt            <= cnt + CW'(1);
          end
        end
        default: begin
          state       <= IDLE;
          level       <= 1'b0;
          bus.btn_out <= 1'b0;
          bus.busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
